// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous instruction memory
// and presents PC/instruction/valid to the IF/ID register with stall, redirect and wrap.
module if_fetch_unit #(
    parameter int unsigned                PC_WIDTH    = 8,
    parameter int unsigned                INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]        RESET_PC    = '0,
    parameter int unsigned                CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_in,
    input  logic                   redirect_in,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   valid_out,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]             state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    req_pc;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic                   delivered;

    assign imem_addr = pc;
    assign pc_out    = req_pc;
    assign valid_out = (state != BOOT) && !redirect_in;
    assign delivered = valid_out && !stall_in;

    always_comb begin
        instr_out = '0;
        case (state)
            RUN:     instr_out = imem_rdata;
            HOLD:    instr_out = hold_instr;
            default: instr_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            hold_instr  <= '0;
            fetch_count <= '0;
        end else begin
            if (delivered && (fetch_count != '1))
                fetch_count <= fetch_count + CNT_WIDTH'(1);

            // Redirect squashes everything; req_pc/hold_instr are left as-is since BOOT ignores them.
            if (redirect_in) begin
                state <= BOOT;
                pc    <= redirect_pc;
            end else begin
                case (state)
                    BOOT: begin
                        state  <= RUN;
                        req_pc <= pc;
                        pc     <= pc + PC_WIDTH'(1);
                    end
                    RUN: begin
                        if (stall_in) begin
                            state      <= HOLD;
                            hold_instr <= imem_rdata;
                        end else begin
                            req_pc <= pc;
                            pc     <= pc + PC_WIDTH'(1);
                        end
                    end
                    HOLD: begin
                        // Memory kept reading pc during the stall, so rdata is valid next cycle.
                        if (!stall_in) begin
                            state  <= RUN;
                            req_pc <= pc;
                            pc     <= pc + PC_WIDTH'(1);
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit with a mem[a] = 0x1000_0000 + a model,
// plus a narrow-counter instance for fetch_count saturation.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [7:0]  pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic [15:0] fetch_count;

    logic        rst2 = 1'b1;
    logic [7:0]  imem_addr2;
    logic [7:0]  pc_out2;
    logic [31:0] instr_out2;
    logic        valid_out2;
    logic [2:0]  fetch_count2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .PC_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(8'h00), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_in(redirect_in),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out),
        .fetch_count(fetch_count)
    );

    if_fetch_unit #(
        .PC_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(8'h00), .CNT_WIDTH(3)
    ) dut_sat (
        .clk(clk), .rst(rst2), .stall_in(1'b0), .redirect_in(1'b0),
        .redirect_pc(8'h00), .imem_addr(imem_addr2), .imem_rdata(32'h0),
        .pc_out(pc_out2), .instr_out(instr_out2), .valid_out(valid_out2),
        .fetch_count(fetch_count2)
    );

    always_ff @(posedge clk)
        imem_rdata <= 32'h1000_0000 + {24'h0, imem_addr};

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [7:0]  rpc;
        logic        chk_pc;
        logic        valid;
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [7:0]  addr;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vec [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    endtask

    initial begin
        //            rst stl rdr rpc    chk val pc     instr          addr   cnt
        vec[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,32'h0000_0000,8'h00,16'd0};
        vec[1]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,32'h0000_0000,8'h00,16'd0};
        vec[2]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h00,32'h1000_0000,8'h01,16'd0};
        vec[3]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h01,32'h1000_0001,8'h02,16'd1};
        vec[4]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h02,32'h1000_0002,8'h03,16'd2};
        vec[5]  = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b1,8'h03,32'h1000_0003,8'h04,16'd3};
        vec[6]  = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b1,8'h03,32'h1000_0003,8'h04,16'd3};
        vec[7]  = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b1,8'h03,32'h1000_0003,8'h04,16'd3};
        vec[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h03,32'h1000_0003,8'h04,16'd3};
        vec[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h04,32'h1000_0004,8'h05,16'd4};
        vec[10] = '{1'b0,1'b0,1'b1,8'h40,1'b1,1'b0,8'h05,32'h1000_0005,8'h06,16'd5};
        vec[11] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,32'h0000_0000,8'h40,16'd5};
        vec[12] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h40,32'h1000_0040,8'h41,16'd5};
        vec[13] = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b1,8'h41,32'h1000_0041,8'h42,16'd6};
        vec[14] = '{1'b0,1'b1,1'b1,8'h20,1'b1,1'b0,8'h41,32'h1000_0041,8'h42,16'd6};
        vec[15] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,32'h0000_0000,8'h20,16'd6};
        vec[16] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h20,32'h1000_0020,8'h21,16'd6};
        vec[17] = '{1'b0,1'b0,1'b1,8'hFE,1'b1,1'b0,8'h21,32'h1000_0021,8'h22,16'd7};
        vec[18] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,32'h0000_0000,8'hFE,16'd7};
        vec[19] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'hFE,32'h1000_00FE,8'hFF,16'd7};
        vec[20] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'hFF,32'h1000_00FF,8'h00,16'd8};
        vec[21] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h00,32'h1000_0000,8'h01,16'd9};
        vec[22] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h01,32'h1000_0001,8'h02,16'd10};
        vec[23] = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b1,8'h02,32'h1000_0002,8'h03,16'd11};
        vec[24] = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b1,8'h02,32'h1000_0002,8'h03,16'd11};
        vec[25] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,32'h0000_0000,8'h00,16'd0};
        vec[26] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h00,32'h1000_0000,8'h01,16'd0};
        vec[27] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,8'h01,32'h1000_0001,8'h02,16'd1};

        rst = 1'b1;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst         = vec[i].rst;
            stall_in    = vec[i].stall;
            redirect_in = vec[i].redir;
            redirect_pc = vec[i].rpc;
            #1;
            check("valid_out", i, {31'h0, valid_out}, {31'h0, vec[i].valid});
            if (vec[i].chk_pc)
                check("pc_out", i, {24'h0, pc_out}, {24'h0, vec[i].pc});
            check("instr_out", i, instr_out, vec[i].instr);
            check("imem_addr", i, {24'h0, imem_addr}, {24'h0, vec[i].addr});
            check("fetch_count", i, {16'h0, fetch_count}, {16'h0, vec[i].cnt});
        end

        // Saturation on a 3-bit counter: BOOT cycle then one delivery per cycle.
        @(negedge clk);
        rst2 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rst2 = 1'b0;
            #1;
            check("sat_valid", k, {31'h0, valid_out2}, (k == 0) ? 32'd0 : 32'd1);
            check("sat_count", k, {29'h0, fetch_count2},
                  (k == 0) ? 32'd0 : ((k - 1) > 7 ? 32'd7 : 32'(k - 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the program counter and issues word addresses to a synchronous-read instruction memory (1-cycle read latency). It presents the fetched PC, instruction and a valid flag to IF/ID. It supports stall (hold), redirect (branch/jump with squash) and PC wrap-around.

Parameters:
PC_WIDTH, 8, width of PC and instruction memory address
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
CNT_WIDTH, 16, width of delivered-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall_in  input  1  downstream hold request; hold outputs and PC
redirect_in  input  1  branch/jump taken; squash current fetch and load redirect_pc
redirect_pc  input  PC_WIDTH  redirect target address
imem_addr  output  PC_WIDTH  instruction memory read address (= pc register, combinational)
imem_rdata  input  INSTR_WIDTH  memory data for address presented the previous cycle
pc_out  output  PC_WIDTH  PC of the presented instruction (= req_pc register)
instr_out  output  INSTR_WIDTH  presented instruction
valid_out  output  1  presented instruction is valid, not squashed
fetch_count  output  CNT_WIDTH  count of delivered instructions, saturating

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high, and has priority over everything.
- Registers:
  - pc: next address to issue.
  - req_pc: address issued last cycle.
  - state: BOOT, RUN or HOLD.
  - hold_instr, fetch_count.
- Reset values:
  - state=BOOT, pc=RESET_PC, req_pc=RESET_PC, hold_instr=0, fetch_count=0.
  - Hence valid_out=0, pc_out=RESET_PC, instr_out=0, imem_addr=RESET_PC.
- Output decode:
  - instr_out = 0 in BOOT, hold_instr in HOLD, imem_rdata in RUN.
  - valid_out = (state != BOOT) & ~redirect_in. Redirect squashes combinationally.
  - pc_out = req_pc.
- Delivery: an instruction is delivered in a cycle where valid_out=1 and stall_in=0. fetch_count increments by 1 in that cycle and saturates at all-ones.
- Transitions (priority: rst > redirect_in > stall_in):
  - Any state, redirect_in=1: go to BOOT; pc<=redirect_pc. req_pc and hold_instr are don't-care.
  - BOOT, no redirect: go to RUN; req_pc<=pc; pc<=pc+1. stall_in is ignored in BOOT because there is nothing to hold.
  - RUN, stall_in=1: go to HOLD; hold_instr<=imem_rdata; pc and req_pc unchanged.
  - RUN, stall_in=0: stay in RUN; req_pc<=pc; pc<=pc+1.
  - HOLD, stall_in=1: stay in HOLD; no register changes.
  - HOLD, stall_in=0: go to RUN; req_pc<=pc; pc<=pc+1. Memory has been reading pc throughout the stall, so imem_rdata is correct in the following cycle.
- Latency:
  - First valid instruction appears 2 cycles after rst deasserts.
  - Redirect costs 2 invalid cycles: the redirect cycle (squashed) plus one BOOT bubble. Target is valid on the 2nd cycle after the redirect cycle.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH, so 0xFF wraps to 0x00 with no flag. Redirect accepts any PC_WIDTH value.
- Stall stability: while stall_in=1 and no redirect, pc_out, instr_out, valid_out and imem_addr are bit-stable.
- Simultaneous stall_in and redirect_in: redirect wins; hold contents are discarded.
- Reset mid-operation: any state returns to the reset values next cycle; an in-flight fetch is discarded.

Test Plan:
(Memory model for all tests: mem[a] = 32'h1000_0000 + a, 1-cycle read.)
1. Reset and run: rst=1 for 2 cycles, then release -> cycle 1 valid_out=0, imem_addr=0x00; cycle 2 valid_out=1, pc_out=0x00, instr_out=0x10000000; cycle 3 pc_out=0x01; fetch_count=2 after cycle 3.
2. Stall: assert stall_in for 3 cycles while pc_out=0x03 -> pc_out=0x03, instr_out=0x10000003, imem_addr=0x04 held, fetch_count frozen; release -> next cycle pc_out=0x04, instr_out=0x10000004.
3. Redirect: pulse redirect_in with redirect_pc=0x40 while pc_out=0x05 -> valid_out=0 that cycle and the next (imem_addr=0x40); following cycle valid_out=1, pc_out=0x40, instr_out=0x10000040; fetch_count excludes 0x05.
4. Redirect during HOLD: stall_in=1 and redirect_in=1 with redirect_pc=0x20 -> BOOT next cycle, hold discarded; pc_out=0x20 valid 2 cycles after the redirect with stall low.
5. Wrap: redirect to 0xFE and run -> pc_out sequence 0xFE, 0xFF, 0x00, 0x01; instr_out matches mem at each address.
6. Reset mid-stall: rst=1 while in HOLD -> next cycle valid_out=0, pc_out=RESET_PC, instr_out=0, fetch_count=0; normal fetch resumes from RESET_PC after release.
